// File: rtl/stable_timer.sv
// stable_timer: consumer of the 64-bit stable counter.
//   - Constant-frequency timer CSRs: TID (0x40), TCFG (0x41), TVAL (0x42), TICLR (0x44).
//   - rdcnt{vl,vh,id}.w read path to EX, one-cycle registered latency.
//   - Level timer interrupt (TI) towards ESTAT.IS[11].
// Optional feature macro: RDCNT_SNAPSHOT_EN
//   defined   : VL also captures cnt[63:32]; a later VH returns that capture so a
//               VL/VH pair stays coherent across a low-word carry.
//   undefined : VH returns live cnt[63:32]; no snapshot register exists.
module stable_timer #(
  parameter int unsigned TIMER_WIDTH = 32,
  parameter logic [31:0] TID_RESET   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cnt,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  input  logic        rdcnt_valid,
  input  logic [1:0]  rdcnt_op,
  output logic        rdcnt_rvalid,
  output logic [31:0] rdcnt_rdata,
  output logic        timer_int
);

  localparam logic [13:0] CSR_TID   = 14'h40;
  localparam logic [13:0] CSR_TCFG  = 14'h41;
  localparam logic [13:0] CSR_TVAL  = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;

  localparam logic [TIMER_WIDTH-1:0] TVAL_ONE = TIMER_WIDTH'(1);

  typedef enum logic [1:0] {
    OP_VL   = 2'd0,
    OP_VH   = 2'd1,
    OP_ID   = 2'd2,
    OP_RSVD = 2'd3
  } rdcnt_op_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TIMER_WIDTH-1:0] tcfg_q,  tcfg_d;
  logic [TIMER_WIDTH-1:0] tval_q,  tval_d;
  logic                   armed_q, armed_d;
  logic                   ti_q,    ti_d;
  logic [31:0]            tid_q,   tid_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q,  rdata_d;
`ifdef RDCNT_SNAPSHOT_EN
  logic [31:0]            snap_q,   snap_d;
`endif

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic wr_tcfg;
  logic wr_tid;
  logic clr_ti;
  logic expire;

  assign wr_tcfg = csr_we && (csr_waddr == CSR_TCFG);
  assign wr_tid  = csr_we && (csr_waddr == CSR_TID);
  assign clr_ti  = csr_we && (csr_waddr == CSR_TICLR) && csr_wdata[0];

  // A TCFG write owns TVAL on its edge, so the countdown (and expiry) is
  // suppressed that cycle.
  assign expire  = armed_q && !wr_tcfg && (tval_q == '0);

  logic [TIMER_WIDTH-1:0] reload_wr;
  logic [TIMER_WIDTH-1:0] reload_cfg;

  assign reload_wr  = {csr_wdata[TIMER_WIDTH-1:2], 2'b00};
  assign reload_cfg = {tcfg_q[TIMER_WIDTH-1:2], 2'b00};

  // Timer next state: configuration write, countdown, periodic reload or disarm.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    tcfg_d  = tcfg_q;
    tval_d  = tval_q;
    armed_d = armed_q;
    if (wr_tcfg) begin
      tcfg_d = csr_wdata[TIMER_WIDTH-1:0];
      if (csr_wdata[0]) begin
        tval_d  = reload_wr;
        armed_d = 1'b1;
      end else begin
        armed_d = 1'b0;
      end
    end else if (armed_q) begin
      if (tval_q != '0) begin
        tval_d = tval_q - TVAL_ONE;
      end else if (tcfg_q[1]) begin
        tval_d = reload_cfg;
      end else begin
        // One-shot: stop at zero so the expiry fires exactly once.
        armed_d = 1'b0;
      end
    end
  end

  // Interrupt flag: expiry has priority over a simultaneous clear.
  always_comb begin
    ti_d = ti_q;
    if (clr_ti) ti_d = 1'b0;
    if (expire) ti_d = 1'b1;
  end

  // TID update; the rdcnt path below deliberately sees the pre-write value.
  always_comb begin
    tid_d = wr_tid ? csr_wdata : tid_q;
  end

  // rdcnt result select, registered one cycle later.
  always_comb begin
    rvalid_d = rdcnt_valid;
    rdata_d  = rdata_q;
`ifdef RDCNT_SNAPSHOT_EN
    snap_d   = snap_q;
`endif
    if (rdcnt_valid) begin
      unique case (rdcnt_op_e'(rdcnt_op))
        OP_VL: begin
          rdata_d = cnt[31:0];
`ifdef RDCNT_SNAPSHOT_EN
          snap_d  = cnt[63:32];
`endif
        end
`ifdef RDCNT_SNAPSHOT_EN
        OP_VH:   rdata_d = snap_q;
`else
        OP_VH:   rdata_d = cnt[63:32];
`endif
        OP_ID:   rdata_d = tid_q;
        OP_RSVD: rdata_d = 32'h0;
        default: rdata_d = 32'h0;
      endcase
    end
  end

  // CSR read mux: current register state only, no write-to-read bypass.
  always_comb begin
    unique case (csr_raddr)
      CSR_TID:   csr_rdata = tid_q;
      CSR_TCFG:  csr_rdata = 32'(tcfg_q);
      CSR_TVAL:  csr_rdata = 32'(tval_q);
      CSR_TICLR: csr_rdata = 32'h0;
      default:   csr_rdata = 32'h0;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      tcfg_q   <= '0;
      tval_q   <= '0;
      armed_q  <= 1'b0;
      ti_q     <= 1'b0;
      tid_q    <= TID_RESET;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
`ifdef RDCNT_SNAPSHOT_EN
      snap_q   <= 32'h0;
`endif
    end else begin
      tcfg_q   <= tcfg_d;
      tval_q   <= tval_d;
      armed_q  <= armed_d;
      ti_q     <= ti_d;
      tid_q    <= tid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
`ifdef RDCNT_SNAPSHOT_EN
      snap_q   <= snap_d;
`endif
    end
  end

  assign rdcnt_rvalid = rvalid_q;
  assign rdcnt_rdata  = rdata_q;
  assign timer_int    = ti_q;

endmodule

// File: tb/tb_stable_timer.sv
// Self-checking bench for stable_timer: directed scenarios followed by random
// stimulus, both checked against a time-based reference model of the timer.
module tb_stable_timer;

  localparam logic [31:0] TID_RESET = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cnt;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        rdcnt_valid;
  logic [1:0]  rdcnt_op;
  logic        rdcnt_rvalid;
  logic [31:0] rdcnt_rdata;
  logic        timer_int;

  always #5 clk = ~clk;

  stable_timer #(.TIMER_WIDTH(32), .TID_RESET(TID_RESET)) dut (
    .clk          (clk),
    .rst          (rst),
    .cnt          (cnt),
    .csr_we       (csr_we),
    .csr_waddr    (csr_waddr),
    .csr_wdata    (csr_wdata),
    .csr_raddr    (csr_raddr),
    .csr_rdata    (csr_rdata),
    .rdcnt_valid  (rdcnt_valid),
    .rdcnt_op     (rdcnt_op),
    .rdcnt_rvalid (rdcnt_rvalid),
    .rdcnt_rdata  (rdcnt_rdata),
    .timer_int    (timer_int)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The countdown is described by time since arming:
  // with load L and k edges elapsed, TVAL = L - (k mod (L+1)) when periodic,
  // max(L-k,0) when one-shot; expiry is the edge on which TVAL is observed 0.
  // ---------------------------------------------------------------------------
  logic [31:0] m_tcfg, m_tid, m_rdata, m_snap;
  logic        m_ti, m_rvalid, m_armed;
  longint      m_k, m_frozen;

  function automatic longint m_load();
    return longint'(m_tcfg & 32'hFFFF_FFFC);
  endfunction

  function automatic longint m_tval();
    longint l = m_load();
    if (!m_armed)  return m_frozen;
    if (m_tcfg[1]) return l - (m_k % (l + 1));
    return (m_k <= l) ? l - m_k : 0;
  endfunction

  function automatic logic [31:0] m_csr(input logic [13:0] a);
    case (a)
      14'h40:  return m_tid;
      14'h41:  return m_tcfg;
      14'h42:  return 32'(m_tval());
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_tcfg = 0; m_tid = TID_RESET; m_rdata = 0; m_snap = 0;
    m_ti = 0; m_rvalid = 0; m_armed = 0; m_k = 0; m_frozen = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit     wr_tcfg, wr_tid, clr, exp_now;
    longint l;
    if (rst) begin
      m_reset();
      return;
    end
    wr_tcfg = csr_we && csr_waddr == 14'h41;
    wr_tid  = csr_we && csr_waddr == 14'h40;
    clr     = csr_we && csr_waddr == 14'h44 && csr_wdata[0];
    l       = m_load();
    exp_now = m_armed && !wr_tcfg && (m_tval() == 0);

    m_rvalid = rdcnt_valid;
    if (rdcnt_valid) begin
      case (rdcnt_op)
        2'd0: begin m_rdata = cnt[31:0]; m_snap = cnt[63:32]; end
`ifdef RDCNT_SNAPSHOT_EN
        2'd1: m_rdata = m_snap;
`else
        2'd1: m_rdata = cnt[63:32];
`endif
        2'd2: m_rdata = m_tid;
        default: m_rdata = 0;
      endcase
    end

    if (wr_tcfg) begin
      if (csr_wdata[0]) begin
        m_armed = 1; m_k = 0;
      end else begin
        m_frozen = m_tval(); m_armed = 0;
      end
      m_tcfg = csr_wdata;
    end else if (m_armed) begin
      if (exp_now && !m_tcfg[1]) begin
        m_armed = 0; m_frozen = 0;
      end else begin
        m_k++;
      end
    end

    if (exp_now) m_ti = 1;
    else if (clr) m_ti = 0;
    if (wr_tid) m_tid = csr_wdata;
    if (l < 0) m_k = 0;
  endtask

  // Called at a falling edge with inputs driven: check the read mux, advance
  // one edge, then check the registered outputs at the next falling edge.
  task automatic tick();
    #1;
    check("csr_rdata", {32'h0, csr_rdata}, {32'h0, m_csr(csr_raddr)});
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("timer_int", {63'h0, timer_int}, {63'h0, m_ti});
    check("rdcnt_rvalid", {63'h0, rdcnt_rvalid}, {63'h0, m_rvalid});
    if (m_rvalid) check("rdcnt_rdata", {32'h0, rdcnt_rdata}, {32'h0, m_rdata});
  endtask

  task automatic idle();
    rst = 0; csr_we = 0; csr_waddr = 14'h0; csr_wdata = 0;
    rdcnt_valid = 0; rdcnt_op = 0; csr_raddr = 14'h42;
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    csr_we = 1; csr_waddr = a; csr_wdata = d;
    tick();
    csr_we = 0;
  endtask

  task automatic rdcnt(input logic [1:0] op);
    rdcnt_valid = 1; rdcnt_op = op;
    tick();
    rdcnt_valid = 0;
  endtask

  task automatic run_until_tval(input longint v, input string tag);
    int n = 0;
    while (m_tval() != v && n < 100) begin tick(); n++; end
    if (n >= 100) check({tag, "_timeout"}, 64'(n), 64'(0));
  endtask

  initial begin
    idle();
    cnt = 64'h0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    m_reset();
    check("reset_ti", {63'h0, timer_int}, 64'h0);
    check("reset_rvalid", {63'h0, rdcnt_rvalid}, 64'h0);
    check("reset_rdata", {32'h0, rdcnt_rdata}, 64'h0);
    rst = 0;

    // One-shot InitVal=5.
    csr_write(14'h41, 32'h15);
    check("t1_tval_load", {32'h0, csr_rdata}, 64'h14);
    repeat (20) tick();
    check("t1_tval_zero", {32'h0, csr_rdata}, 64'h0);
    check("t1_ti_before", {63'h0, timer_int}, 64'h0);
    tick();
    check("t1_ti_set", {63'h0, timer_int}, 64'h1);
    repeat (10) tick();
    check("t1_tval_hold", {32'h0, csr_rdata}, 64'h0);

    // Periodic InitVal=1, clear on a non-expiry cycle, re-assert on next expiry.
    csr_write(14'h44, 32'h1);
    check("t2_ti_clr0", {63'h0, timer_int}, 64'h0);
    csr_write(14'h41, 32'h7);
    repeat (5) tick();
    check("t2_ti_first", {63'h0, timer_int}, 64'h1);
    check("t2_reload", {32'h0, csr_rdata}, 64'h4);
    csr_write(14'h44, 32'h1);
    check("t2_ti_clr", {63'h0, timer_int}, 64'h0);
    run_until_tval(0, "t2");
    tick();
    check("t2_ti_again", {63'h0, timer_int}, 64'h1);

    // Clear on the exact expiry cycle loses to the set; then disarm mid-count.
    csr_write(14'h44, 32'h1);
    run_until_tval(0, "t3");
    csr_write(14'h44, 32'h1);
    check("t3_set_wins", {63'h0, timer_int}, 64'h1);
    run_until_tval(2, "t3b");
    csr_write(14'h41, 32'h6);
    repeat (3) tick();
    check("t3_frozen", {32'h0, csr_rdata}, 64'h2);
    check("t3_ti_kept", {63'h0, timer_int}, 64'h1);

    // VL/VH across a low-word carry.
    cnt = 64'h0000_0001_FFFF_FFFF;
    rdcnt(2'd0);
    check("t4_vl", {32'h0, rdcnt_rdata}, 64'hFFFF_FFFF);
    cnt = 64'h0000_0002_0000_0000;
    rdcnt(2'd1);
`ifdef RDCNT_SNAPSHOT_EN
    check("t4_vh", {32'h0, rdcnt_rdata}, 64'h1);
`else
    check("t4_vh", {32'h0, rdcnt_rdata}, 64'h2);
`endif

    // TID write alongside an ID request returns the old value.
    csr_we = 1; csr_waddr = 14'h40; csr_wdata = 32'h1234;
    rdcnt(2'd2);
    csr_we = 0;
    check("t5_id_old", {32'h0, rdcnt_rdata}, {32'h0, TID_RESET});
    rdcnt(2'd2);
    check("t5_id_new", {32'h0, rdcnt_rdata}, 64'h1234);
    rdcnt(2'd3);
    check("t5_rsvd_valid", {63'h0, rdcnt_rvalid}, 64'h1);
    check("t5_rsvd_data", {32'h0, rdcnt_rdata}, 64'h0);

    // Reset during periodic countdown with TI set and an rdcnt in flight.
    csr_write(14'h41, 32'hB);
    run_until_tval(0, "t6");
    tick();
    tick();
    check("t6_ti_pre", {63'h0, timer_int}, 64'h1);
    rdcnt_valid = 1; rdcnt_op = 2'd0; rst = 1;
    tick();
    rdcnt_valid = 0; rst = 0;
    check("t6_ti", {63'h0, timer_int}, 64'h0);
    check("t6_rvalid", {63'h0, rdcnt_rvalid}, 64'h0);
    csr_raddr = 14'h41;
    #1 check("t6_tcfg", {32'h0, csr_rdata}, 64'h0);
    csr_raddr = 14'h42;
    #1 check("t6_tval", {32'h0, csr_rdata}, 64'h0);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [13:0] addrs [5];
      addrs = '{14'h40, 14'h41, 14'h42, 14'h44, 14'h43};
      idle();
      rst = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 99);
      csr_waddr = addrs[$urandom_range(0, 4)];
      csr_wdata = $urandom();
      if (r < 4) begin
        csr_we = 1; csr_waddr = 14'h41;
        csr_wdata = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 1) << 1)
                  | 32'($urandom_range(0, 9) != 0);
      end else if (r < 14) begin
        csr_we = 1; csr_waddr = 14'h44;
      end else if (r < 18) begin
        csr_we = 1; csr_waddr = 14'h40;
      end else if (r < 25) begin
        csr_we = 1; csr_waddr = ($urandom_range(0, 1) == 0) ? 14'h42 : 14'($urandom());
      end
      csr_raddr   = ($urandom_range(0, 1) == 0) ? 14'h42 : addrs[$urandom_range(0, 4)];
      rdcnt_valid = $urandom_range(0, 1);
      rdcnt_op    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) cnt = {$urandom(), $urandom()};
      else cnt = cnt + 64'($urandom_range(1, 3));
      tick();
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
